// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// instruction word field positions, ALU opcode constants and a helper.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Instruction word layout: [11] type (0 ALU, 1 RAM), [10] rw, [10:8] opcode, [7:0] imm
    localparam int INSTR_W  = 12;
    localparam int TYPE_BIT = 11;
    localparam int RW_BIT   = 10;
    localparam int OPC_MSB  = 10;
    localparam int OPC_LSB  = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // Saturating 8-bit increment used for the retired-instruction counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// ROM fetch, ALU operand and RAM handshake bus of the instruction sequencer.
interface instr_sequencer_if #(
    parameter int PC_W = 2
);
    logic [PC_W-1:0] rom_addr;
    logic [11:0]     instr;
    logic [2:0]      opcode;
    logic [7:0]      imm;
    logic            acc_we;
    logic            ram_req;
    logic            ram_we;
    logic            ram_ack;

    modport master (
        output rom_addr, opcode, imm, acc_we, ram_req, ram_we,
        input  instr, ram_ack
    );

    modport slave (
        input  rom_addr, opcode, imm, acc_we, ram_req, ram_we,
        output instr, ram_ack
    );
endinterface

// File: rtl/instr_sequencer_mem_wait_timer.sv
// Wait-cycle counter for the MEM state: cleared on load, advanced while
// counting, and flags expiry in the TIMEOUT-th counted cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Counter register: load clears, count advances until expiry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (count && !expire) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end
endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer top: fetch/decode/execute/memory/write-back FSM.
// Optional build macro SINGLE_STEP_EN adds a step input that gates FETCH.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W        = 2,
    parameter int PROG_LEN    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                loop,
    input  logic                halt_req,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    instr_sequencer_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [7:0]          retired
);
    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [11:0]        ir_q, ir_d;
    logic [2:0]         opcode_q, opcode_d;
    logic [7:0]         imm_q, imm_d;
    logic               type_q, type_d;
    logic               rw_q, rw_d;
    logic               acc_we_q, acc_we_d;
    logic               ram_req_q, ram_req_d;
    logic               ram_we_q, ram_we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         retired_q, retired_d;

    logic               timer_load_s;
    logic               timer_count_s;
    logic               timer_expire_s;
    logic               fetch_go_s;
    logic               last_instr_s;

`ifdef SINGLE_STEP_EN
    assign fetch_go_s = step;
`else
    assign fetch_go_s = 1'b1;
`endif

    assign last_instr_s = (pc_q == PC_W'(PROG_LEN - 1));

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load_s),
        .count  (timer_count_s),
        .expire (timer_expire_s)
    );

    // Next-state and next-output logic; WB-related outputs are loaded on WB entry
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        opcode_d      = opcode_q;
        imm_d         = imm_q;
        type_d        = type_q;
        rw_d          = rw_q;
        acc_we_d      = 1'b0;
        ram_req_d     = ram_req_q;
        ram_we_d      = ram_we_q;
        done_d        = 1'b0;
        err_d         = err_q;
        retired_d     = retired_q;
        timer_load_s  = 1'b0;
        timer_count_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (fetch_go_s) begin
                    state_d = S_DECODE;
                    ir_d    = bus.instr;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                opcode_d = ir_q[OPC_MSB:OPC_LSB];
                imm_d    = ir_q[IMM_MSB:IMM_LSB];
                type_d   = ir_q[TYPE_BIT];
                rw_d     = ir_q[RW_BIT];
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                if (type_q) begin
                    state_d      = S_MEM;
                    ram_req_d    = 1'b1;
                    ram_we_d     = rw_q;
                    timer_load_s = 1'b1;
                end else begin
                    state_d   = S_WB;
                    acc_we_d  = 1'b1;
                    done_d    = last_instr_s;
                    retired_d = sat_inc8(retired_q);
                end
            end
            S_MEM: begin
                timer_count_s = 1'b1;
                if (bus.ram_ack) begin
                    state_d   = S_WB;
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                    done_d    = last_instr_s;
                    retired_d = sat_inc8(retired_q);
                end else if (timer_expire_s) begin
                    state_d   = S_HALT;
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    state_d   = S_MEM;
                end
            end
            S_WB: begin
                if (last_instr_s) begin
                    pc_d    = '0;
                    state_d = (loop && !halt_req) ? S_FETCH : S_IDLE;
                end else begin
                    pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    state_d = halt_req ? S_IDLE : S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= 12'h000;
            opcode_q  <= 3'b000;
            imm_q     <= 8'h00;
            type_q    <= 1'b0;
            rw_q      <= 1'b0;
            acc_we_q  <= 1'b0;
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            imm_q     <= imm_d;
            type_q    <= type_d;
            rw_q      <= rw_d;
            acc_we_q  <= acc_we_d;
            ram_req_q <= ram_req_d;
            ram_we_q  <= ram_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    assign bus.rom_addr = pc_q;
    assign bus.opcode   = opcode_q;
    assign bus.imm      = imm_q;
    assign bus.acc_we   = acc_we_q;
    assign bus.ram_req  = ram_req_q;
    assign bus.ram_we   = ram_we_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign retired      = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (4-word ROM model,
// RAM responder with programmable ack delay, negedge output monitor).
module tb_instr_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       loop = 1'b0;
    logic       halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b0;
`endif
    logic       busy, done, err;
    logic [7:0] retired;

    logic [11:0] rom [0:3];
    logic        ram_ack_r = 1'b0;
    int          ack_delay = 0;
    int          req_run = 0;

    int          n_tests = 0;
    int          n_fail = 0;

    int          acc_cnt = 0, done_cnt = 0, req_cnt = 0, we_cnt = 0, busy_cnt = 0;
    logic [11:0] opc_hist = 12'h000;
    logic [7:0]  imm_at_req = 8'h00;

    instr_sequencer_if #(.PC_W(2)) bus ();

    assign bus.instr   = rom[bus.rom_addr];
    assign bus.ram_ack = ram_ack_r;

    instr_sequencer #(
        .PC_W        (2),
        .PROG_LEN    (4),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .loop     (loop),
        .halt_req (halt_req),
`ifdef SINGLE_STEP_EN
        .step     (step),
`endif
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Observe outputs mid-cycle and answer RAM requests after ack_delay cycles
    always @(negedge clk) begin
        if (bus.acc_we) begin
            acc_cnt  <= acc_cnt + 1;
            opc_hist <= {opc_hist[8:0], bus.opcode};
        end
        if (done)                     done_cnt <= done_cnt + 1;
        if (busy)                     busy_cnt <= busy_cnt + 1;
        if (bus.ram_req && bus.ram_we) we_cnt  <= we_cnt + 1;
        if (bus.ram_req) begin
            req_cnt    <= req_cnt + 1;
            imm_at_req <= bus.imm;
            req_run    <= req_run + 1;
            ram_ack_r  <= (ack_delay != 0) && (req_run + 1 == ack_delay);
        end else begin
            req_run    <= 0;
            ram_ack_r  <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget, input string tag);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        check_eq(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic load_rom(input logic [11:0] w0, input logic [11:0] w1,
                            input logic [11:0] w2, input logic [11:0] w3);
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    initial begin
        int a0, d0, r0, w0, b0;
        load_rom(12'h305, 12'h003, 12'h000, 12'h702);

        // Reset state
        do_reset();
        check_eq("rst_rom_addr", {30'd0, bus.rom_addr}, 32'd0);
        check_eq("rst_opcode",   {29'd0, bus.opcode}, 32'd0);
        check_eq("rst_imm",      {24'd0, bus.imm}, 32'd0);
        check_eq("rst_acc_we",   {31'd0, bus.acc_we}, 32'd0);
        check_eq("rst_ram_req",  {31'd0, bus.ram_req}, 32'd0);
        check_eq("rst_ram_we",   {31'd0, bus.ram_we}, 32'd0);
        check_eq("rst_busy",     {31'd0, busy}, 32'd0);
        check_eq("rst_done",     {31'd0, done}, 32'd0);
        check_eq("rst_err",      {31'd0, err}, 32'd0);
        check_eq("rst_retired",  {24'd0, retired}, 32'd0);

        // All-ALU program, no loop; extra start mid-run must be ignored
        a0 = acc_cnt; d0 = done_cnt; b0 = busy_cnt;
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_not_busy(100, "alu_idle");
        check_eq("alu_acc_pulses", acc_cnt - a0, 4);
        check_eq("alu_opcodes",    {20'd0, opc_hist}, 32'h607);
        check_eq("alu_done",       done_cnt - d0, 1);
        check_eq("alu_retired",    {24'd0, retired}, 32'd4);
        check_eq("alu_busy_cycles", busy_cnt - b0, 16);
        check_eq("alu_pc_wrap",    {30'd0, bus.rom_addr}, 32'd0);

        // RAM read at pc=1 acked after 3 MEM cycles
        do_reset();
        load_rom(12'h305, 12'h8AA, 12'h000, 12'h702);
        ack_delay = 3;
        a0 = acc_cnt; d0 = done_cnt; r0 = req_cnt; w0 = we_cnt; b0 = busy_cnt;
        pulse_start();
        wait_not_busy(100, "ram_idle");
        check_eq("ram_req_cycles", req_cnt - r0, 3);
        check_eq("ram_we_cycles",  we_cnt - w0, 0);
        check_eq("ram_imm",        {24'd0, imm_at_req}, 32'hAA);
        check_eq("ram_acc_pulses", acc_cnt - a0, 3);
        check_eq("ram_opcodes",    {23'd0, opc_hist[8:0]}, 32'h0C7);
        check_eq("ram_retired",    {24'd0, retired}, 32'd4);
        check_eq("ram_done",       done_cnt - d0, 1);
        check_eq("ram_busy_cycles", busy_cnt - b0, 19);

        // RAM request never acknowledged -> timeout into HALT
        do_reset();
        load_rom(12'h8AA, 12'h003, 12'h000, 12'h702);
        ack_delay = 0;
        r0 = req_cnt;
        pulse_start();
        wait_not_busy(100, "to_stop");
        check_eq("to_req_cycles", req_cnt - r0, 15);
        check_eq("to_err",        {31'd0, err}, 32'd1);
        check_eq("to_ram_req",    {31'd0, bus.ram_req}, 32'd0);
        check_eq("to_retired",    {24'd0, retired}, 32'd0);
        pulse_start();
        repeat (5) @(negedge clk);
        check_eq("to_start_ignored", {31'd0, busy}, 32'd0);
        check_eq("to_err_sticky",    {31'd0, err}, 32'd1);
        do_reset();
        check_eq("to_err_cleared",   {31'd0, err}, 32'd0);

        // Loop mode with halt_req raised during instruction 2
        load_rom(12'h305, 12'h003, 12'h000, 12'h702);
        loop = 1'b1;
        a0 = acc_cnt; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 50 && retired != 8'd1; i++) @(negedge clk);
        check_eq("halt_first_retire", {24'd0, retired}, 32'd1);
        @(negedge clk);
        halt_req = 1'b1;
        wait_not_busy(50, "halt_idle");
        halt_req = 1'b0;
        loop = 1'b0;
        check_eq("halt_retired",    {24'd0, retired}, 32'd2);
        check_eq("halt_no_done",    done_cnt - d0, 0);
        check_eq("halt_acc_pulses", acc_cnt - a0, 2);

        // Reset in the middle of a RAM write request
        do_reset();
        load_rom(12'hC55, 12'h003, 12'h000, 12'h702);
        ack_delay = 0;
        pulse_start();
        for (int i = 0; i < 20 && !bus.ram_req; i++) @(negedge clk);
        check_eq("mr_req_seen", {31'd0, bus.ram_req}, 32'd1);
        check_eq("mr_we_seen",  {31'd0, bus.ram_we}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mr_ram_req", {31'd0, bus.ram_req}, 32'd0);
        check_eq("mr_ram_we",  {31'd0, bus.ram_we}, 32'd0);
        check_eq("mr_busy",    {31'd0, busy}, 32'd0);
        check_eq("mr_opcode",  {29'd0, bus.opcode}, 32'd0);
        check_eq("mr_imm",     {24'd0, bus.imm}, 32'd0);
        ack_delay = 2;
        r0 = req_cnt;
        pulse_start();
        check_eq("mr_restart_pc", {30'd0, bus.rom_addr}, 32'd0);
        wait_not_busy(100, "mr_idle");
        check_eq("mr_req_cycles", req_cnt - r0, 2);
        check_eq("mr_retired",    {24'd0, retired}, 32'd4);
        check_eq("mr_err",        {31'd0, err}, 32'd0);

`ifdef SINGLE_STEP_EN
        // Single-step: one instruction per step pulse, stall in FETCH between
        do_reset();
        load_rom(12'h305, 12'h003, 12'h000, 12'h702);
        pulse_start();
        for (int p = 0; p < 3; p++) begin
            repeat (10) @(negedge clk);
            check_eq("ss_stalled_busy", {31'd0, busy}, 32'd1);
            check_eq("ss_stalled_ret",  {24'd0, retired}, p);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
        repeat (10) @(negedge clk);
        check_eq("ss_retired", {24'd0, retired}, 32'd3);
        check_eq("ss_busy",    {31'd0, busy}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 2, meaning program counter / ROM address width.
REQ-002 SHALL have parameter PROG_LEN, default 4, meaning instruction count before PC wrap (2..2**PC_W).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles waiting for ram_ack.
REQ-004 SHALL have ports: clk in 1 rising-edge clock; rst_n in 1 synchronous active-low reset.
REQ-005 SHALL have ports: start in 1 run pulse; loop in 1 wrap-and-continue select; halt_req in 1 stop after current instruction.
REQ-006 SHALL have ports: rom_addr out PC_W fetch address; instr in 12 ROM word ([11] type, [10] rw, [10:8] opcode, [7:0] imm).
REQ-007 SHALL have ports: opcode out 3 ALU opcode; imm out 8 ALU/RAM operand; acc_we out 1 accumulator write strobe.
REQ-008 SHALL have ports: ram_req out 1 RAM request; ram_we out 1 RAM write select; ram_ack in 1 RAM completion.
REQ-009 SHALL have ports: busy out 1; done out 1 program-end pulse; err out 1 sticky timeout flag; retired out 8 instruction count.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-011 IDLE: start=1 -> FETCH next cycle, pc=0; busy=0 only in IDLE and HALT.
REQ-012 FETCH: rom_addr=pc; instr captured into instruction register on the FETCH->DECODE edge.
REQ-013 DECODE: opcode, imm, type, rw registered from instruction register; -> EXEC; opcode/imm held stable until next DECODE.
REQ-014 EXEC: type=0 -> WB; type=1 -> MEM.
REQ-015 MEM: ram_req=1, ram_we=rw, held stable until ram_ack=1 sampled, then -> WB; ram_req deasserts the cycle after ack.
REQ-016 MEM: wait counter resets on MEM entry; if MEM_TIMEOUT cycles pass without ack -> HALT, err=1, ram_req=0.
REQ-017 WB: acc_we=1 for exactly one cycle if type=0, else 0; retired increments, saturating at 255.
REQ-018 WB: pc==PROG_LEN-1 -> pc=0, done=1 one cycle; then loop=1 -> FETCH, loop=0 -> IDLE.
REQ-019 WB: otherwise pc=pc+1 -> FETCH; halt_req sampled only in WB, and halt_req=1 -> IDLE (overrides loop, done not pulsed unless end reached).
REQ-020 start while busy SHALL be ignored; ram_ack outside MEM SHALL be ignored.
REQ-021 HALT: exited only by reset; busy=0, err=1.
REQ-022 Instruction latency: ALU type 4 cycles; RAM type 4+N cycles, N = cycles in MEM (>=1).

Reset
REQ-023 rst_n=0 at a clk edge SHALL force IDLE, pc=0, rom_addr=0, opcode=0, imm=0, acc_we=0, ram_req=0, ram_we=0, busy=0, done=0, err=0, retired=0, including mid-MEM.

Configuration
REQ-024 Macro SINGLE_STEP_EN defined: extra input step (1 bit); FETCH SHALL stall until step=1 sampled, one instruction per pulse.
REQ-025 Macro SINGLE_STEP_EN undefined: no step port; FETCH always lasts one cycle.

Structure
REQ-026 Shared package SHALL hold state enum, instruction field bit positions, and opcode constants (ADD..NOT, 3'b000..3'b111).
REQ-027 One sub-module mem_wait_timer (load, count, expire) natural for REQ-016; all else in one FSM.

Verification
REQ-028 ROM {0x305,0x003,0x000,0x702}, start, loop=0 -> 4 acc_we pulses, opcode 3,0,0,7, done once, retired=4, IDLE.
REQ-029 ROM[1]=0x8AA (RAM read), ram_ack after 3 cycles -> ram_req high 3 cycles, ram_we=0, imm=0xAA, no acc_we for that instruction.
REQ-030 RAM instruction, ram_ack never -> after 15 MEM cycles err=1, HALT, ram_req=0; start ignored until rst_n=0.
REQ-031 loop=1, halt_req=1 asserted during instruction 2 -> stops in IDLE after its WB, retired=2, no done.
REQ-032 rst_n=0 in MEM with ram_req=1 -> next cycle all outputs at reset values; start restarts from pc=0.
REQ-033 SINGLE_STEP_EN defined, 3 step pulses 10 cycles apart -> retired=3, FSM stalled in FETCH between pulses.
